// File: rtl/eco_bist_pkg.sv
// Shared types and pure functions for the ECO netlist BIST controller:
// state encoding, golden 4-bit response function and MISR step.
package eco_bist_pkg;

    localparam int unsigned N_PAT = 256;
    localparam int unsigned DW    = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned FCW   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference response of the unpatched netlist, built from its internal w-terms.
    function automatic logic [DW-1:0] golden_y(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic w0, w1, w3, w5, w7;
        logic [DW-1:0] g;
        w0   = a[0] ^ b[1];
        w1   = w0 | b[0];
        w3   = a[1] | (a[2] & b[0]);
        w5   = a[3] | b[2];
        w7   = w5 & b[3];
        g[0] = w1 & w3;
        g[1] = ~(w3 & b[1]) ^ b[2];
        g[2] = a[1] | ~(a[3] | w7);
        g[3] = ~(w7 & b[3]);
        return g;
    endfunction

    function automatic logic [DW-1:0] misr_next(input logic [DW-1:0] s, input logic [DW-1:0] y);
        logic [DW-1:0] n;
        n[0] = s[3] ^ y[0];
        n[1] = s[0] ^ y[1];
        n[2] = s[1] ^ y[2];
        n[3] = s[2] ^ s[3] ^ y[3];
        return n;
    endfunction

endpackage

// File: rtl/eco_bist_if.sv
// Stimulus/response and result bundle between the BIST controller and the
// netlist-under-test side of the ECO equivalence bench.
interface eco_bist_if;

    logic                              start;
    logic [eco_bist_pkg::DW-1:0]       a;
    logic [eco_bist_pkg::DW-1:0]       b;
    logic [eco_bist_pkg::DW-1:0]       y;
    logic                              busy;
    logic                              done;
    logic                              pass;
    logic [eco_bist_pkg::DW-1:0]       sig;
    logic [eco_bist_pkg::FCW-1:0]      fail_cnt;
    logic [eco_bist_pkg::CW-1:0]       first_fail_idx;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, sig, fail_cnt, first_fail_idx
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, sig, fail_cnt, first_fail_idx
    );

endinterface

// File: rtl/eco_misr4.sv
// 4-bit multiple-input signature register compacting the response stream.
module eco_misr4
    import eco_bist_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, d);
        end
    end

endmodule

// File: rtl/eco_bist_ctrl.sv
// BIST controller: sweeps all 256 (a,b) patterns through the netlist,
// checks y against the golden function and reports a pass/fail verdict.
module eco_bist_ctrl
    import eco_bist_pkg::*;
#(
    parameter logic [3:0] EXP_SIG = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    eco_bist_if.slave  bus
);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [FCW-1:0]    fail_cnt;
    logic [CW-1:0]     first_fail_idx;
    logic              busy;
    logic              done;
    logic              pass;
    logic [DW-1:0]     misr_sig;

    logic              mismatch;
    logic [FCW-1:0]    fail_next;
    logic [DW-1:0]     sig_next;
    logic              misr_clr;
    logic              misr_en;

    // The pattern counter doubles as the registered stimulus.
    assign bus.a              = cnt[DW-1:0];
    assign bus.b              = cnt[CW-1:DW];
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.sig            = misr_sig;
    assign bus.fail_cnt       = fail_cnt;
    assign bus.first_fail_idx = first_fail_idx;

    assign mismatch  = (bus.y != golden_y(cnt[DW-1:0], cnt[CW-1:DW]));
    assign fail_next = fail_cnt + FCW'(mismatch);
    assign sig_next  = misr_next(misr_sig, bus.y);
    assign misr_clr  = (state == IDLE) && bus.start;
    assign misr_en   = (state == RUN);

    eco_misr4 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .d     (bus.y),
        .sig   (misr_sig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= 8'hFF;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= RUN;
                        cnt            <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= 8'hFF;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        fail_cnt <= fail_next;
                        if (fail_cnt == '0) begin
                            first_fail_idx <= cnt;
                        end
                    end
                    // Last pattern: leave a/b at 4'hF and resolve the verdict from next-state values.
                    if (cnt == CW'(N_PAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == '0) && (sig_next == EXP_SIG);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
